// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_pkg
// Purpose  : Shared definitions for the counter sequencer block: default
//            datapath widths and the sequencer state encoding.
// Contents : C_DEFAULT_WIDTH  - default counter / terminal-value width
//            C_DEFAULT_PRE_W  - default prescaler reload width
//            seq_state_e      - IDLE=0, RUN=1, PAUSE=2, DONE=3
// Revision : 1.0 - initial release
// ============================================================================
package counter_sequencer_pkg;

   localparam int unsigned C_DEFAULT_WIDTH = 8;
   localparam int unsigned C_DEFAULT_PRE_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

endpackage : counter_sequencer_pkg
`default_nettype wire

// File: rtl/counter_sequencer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : seq_prescaler
// Purpose  : PRE_W-bit clock-enable prescaler. Counts enabled cycles and
//            emits a one-cycle step strobe when the count matches the reload
//            value, clearing itself on that same edge.
// Ports    : clk      - system clock
//            reset    - synchronous active-high reset
//            i_en     - advance the prescaler this cycle
//            i_clr    - force the prescaler to zero (wins over i_en)
//            i_reload - compare value (steps per count minus 1)
//            o_step   - step strobe, combinational from the current count
// Revision : 1.0 - initial release
// ============================================================================
module seq_prescaler
   import counter_sequencer_pkg::*;
#(
   parameter int unsigned PRE_W = C_DEFAULT_PRE_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [PRE_W-1:0] i_reload,
   output logic             o_step
);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;

   always_comb begin
      o_step = i_en && (cnt_q == i_reload);
      cnt_d  = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (o_step) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : seq_prescaler
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Purpose  : Programmable timer. Sequences an 8-bit event counter through
//            start / pause / stop / terminal-count expiry with optional
//            auto-reload, stepping the counter through a clock-enable
//            prescaler so slow events are counted on the system clock.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            start, stop           - arm-and-start pulse, abort pulse
//            pause                 - level, freezes the run while high
//            periodic, term,
//            prescale              - run configuration, sampled at start
//            count                 - current counter value
//            busy                  - high in RUN or PAUSE
//            expire                - one-cycle pulse at terminal count
//            state                 - IDLE=0, RUN=1, PAUSE=2, DONE=3
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = C_DEFAULT_WIDTH,
   parameter int unsigned PRE_W = C_DEFAULT_PRE_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             periodic,
   input  logic [WIDTH-1:0] term,
   input  logic [PRE_W-1:0] prescale,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expire,
   output logic [1:0]       state
);

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] term_q, term_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   logic             periodic_q, periodic_d;
   logic             expire_q, expire_d;
   logic             busy_q, busy_d;

   logic             w_active;
   logic             w_pre_en;
   logic             w_pre_clr;
   logic             w_step;

   // A run is live in RUN and PAUSE. Any cycle of a live run with pause low
   // advances the prescaler, including the cycle that leaves PAUSE, so a
   // pause costs exactly as many cycles as pause was held high.
   assign w_active  = (state_q == RUN) || (state_q == PAUSE);
   assign w_pre_en  = w_active && !pause && !stop;
   assign w_pre_clr = stop || (!w_active && start);

   seq_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_pre_en),
      .i_clr    (w_pre_clr),
      .i_reload (prescale_q),
      .o_step   (w_step)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      term_d     = term_q;
      prescale_d = prescale_q;
      periodic_d = periodic_q;
      expire_d   = 1'b0;

      if (stop) begin
         // Abort wins over a coincident terminal step: no expire pulse.
         state_d = IDLE;
         count_d = '0;
      end else if (!w_active) begin
         if (start) begin
            term_d     = term;
            prescale_d = prescale;
            periodic_d = periodic;
            count_d    = '0;
            state_d    = RUN;
         end
      end else if (pause) begin
         state_d = PAUSE;
      end else begin
         state_d = RUN;
         if (w_step) begin
            // Compare before increment so the counter never wraps past term.
            if (count_q == term_q) begin
               expire_d = 1'b1;
               if (periodic_q) begin
                  count_d = '0;
               end else begin
                  state_d = DONE;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
      end

      busy_d = (state_d == RUN) || (state_d == PAUSE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         term_q     <= '0;
         prescale_q <= '0;
         periodic_q <= 1'b0;
         expire_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         term_q     <= term_d;
         prescale_q <= prescale_d;
         periodic_q <= periodic_d;
         expire_q   <= expire_d;
         busy_q     <= busy_d;
      end
   end

   assign count  = count_q;
   assign busy   = busy_q;
   assign expire = expire_q;
   assign state  = state_q;

endmodule : counter_sequencer
`default_nettype wire
